dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Parametrised successor to the single-cycle data RAM on the ARM processor's data port.
- Adds a configurable wait-state memory array and a ready/stall handshake.
- Adds little-endian byte access for LDRB/STRB and out-of-range error reporting.
- Sits between the processor's data interface (DataAdr, WriteData, MemWrite, ReadData) and the on-chip data storage.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 32, byte-address width.
- DEPTH_WORDS, 64, number of DATA_W words in the array; valid byte addresses are 0 to DEPTH_WORDS*(DATA_W/8)-1.
- WAIT_STATES, 1, extra cycles inserted before a response; legal range 0 to 15.
- MMIO_ADDR, 32'h0000_0400, byte address of the output register (used only with the optional feature).

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- mem_req  in  1  access request; held high by the processor until mem_ready
- MemWrite  in  1  1 = store, 0 = load; sampled at acceptance
- byte_op  in  1  1 = byte access, 0 = word access; sampled at acceptance
- DataAdr  in  ADDR_W  byte address; sampled at acceptance
- WriteData  in  DATA_W  store data; for a byte store, bits [7:0] are used
- ReadData  out  DATA_W  load result; valid only while mem_ready=1
- mem_ready  out  1  one-cycle completion pulse
- stall  out  1  combinational: mem_req & ~mem_ready; drives the processor's PC/pipeline enable
- err  out  1  high together with mem_ready when the access was out of range
- led_out  out  DATA_W  memory-mapped output register (optional feature)

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - FSM goes to IDLE; the wait counter clears to 0.
  - mem_ready=0, err=0, ReadData=0, led_out=0.
  - Array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - With mem_req=1, the block latches MemWrite, byte_op, DataAdr and WriteData.
  - It loads the counter with WAIT_STATES and moves to WAIT; if WAIT_STATES=0 it moves straight to RESP.
- WAIT:
  - The counter decrements each cycle.
  - When the counter equals 1, the next state is RESP.
  - Inputs are ignored in this state; only latched values are used.
- RESP:
  - mem_ready=1 for exactly one cycle, then the FSM returns to IDLE.
  - Latency from the acceptance edge to mem_ready high is WAIT_STATES+1 cycles.
  - There is a minimum one idle cycle between accesses; a request held high in IDLE is accepted on that edge.
- Store commit: the array is written on the edge that ends the RESP cycle, never earlier.
- Word access:
  - Index = addr[log2(DEPTH_WORDS)+1:2]; addr[1:0] is ignored (forced alignment).
  - Load returns the full word; store writes the full word.
- Byte access:
  - Lane = addr[1:0], little-endian: lane 0 = bits [7:0], lane 3 = bits [31:24].
  - Load returns the selected byte zero-extended to DATA_W.
  - Store writes WriteData[7:0] into the selected lane only; other lanes are unchanged.
- Out of range (addr >= DEPTH_WORDS*DATA_W/8, and not MMIO_ADDR when the optional feature is enabled):
  - err=1 with mem_ready, ReadData=0, and the store is suppressed.
  - Latency is the same as a normal access.
- ReadData is a registered output. It is held at 0 whenever mem_ready=0, so the processor never sees stale data.
- Reset mid-access (asserted in WAIT or RESP):
  - The access is aborted and no write is committed.
  - No mem_ready pulse is produced.
  - The FSM is in IDLE on the next cycle.
- A mem_req dropped before mem_ready does not abort the access; it completes, and the response is ignored by the processor.

Optional Feature:
- Macro: DMEM_MMIO_EN
- Defined:
  - A word store to MMIO_ADDR updates led_out at the commit edge.
  - A byte store to MMIO_ADDR updates only the addressed lane of led_out.
  - A load from MMIO_ADDR returns led_out, or the selected lane zero-extended for a byte load.
  - MMIO_ADDR never raises err, and the array is not touched.
- Not defined:
  - led_out is tied to 0.
  - MMIO_ADDR is decoded like any other address, so it is out of range unless it lies inside the array.

Test Plan:
- Reset then idle (WAIT_STATES=1) -> mem_ready=0, err=0, ReadData=0, stall=0 for 10 cycles.
- Word store 32'hDEADBEEF at addr 0x10, then word load from 0x10 -> mem_ready exactly 2 cycles after each acceptance; load ReadData=32'hDEADBEEF; stall high for 2 cycles per access.
- Byte store 8'hA5 at 0x11 over word 32'h00000000, then word load from 0x10 -> 32'h0000A500; byte load from 0x11 -> 32'h000000A5.
- Word store to 0x100 with DEPTH_WORDS=64 -> err=1 with mem_ready; a following load from 0x100 returns ReadData=0, err=1; array word 0 is unchanged.
- rst asserted in WAIT during a store of 32'h12345678 to 0x20 -> no mem_ready pulse; a subsequent load from 0x20 returns the prior contents.
- With DMEM_MMIO_EN and WAIT_STATES=0, word store 32'h0000_00FF to 0x400 -> led_out=32'h000000FF on the commit edge, latency 1 cycle; without the macro the same store gives err=1 and led_out stays 0.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data-port memory controller: wait-state RAM with ready/stall handshake, little-endian byte lanes and range error.
// Define DMEM_MMIO_EN to map the led_out output register at MMIO_ADDR.
module dmem_ctrl #(
    parameter int              DATA_W      = 32,
    parameter int              ADDR_W      = 32,
    parameter int              DEPTH_WORDS = 64,
    parameter int              WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] MMIO_ADDR = 'h0000_0400
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_req,
    input  logic              MemWrite,
    input  logic              byte_op,
    input  logic [ADDR_W-1:0] DataAdr,
    input  logic [DATA_W-1:0] WriteData,
    output logic [DATA_W-1:0] ReadData,
    output logic              mem_ready,
    output logic              stall,
    output logic              err,
    output logic [DATA_W-1:0] led_out
);

    localparam int NB     = DATA_W / 8;
    localparam int OFF    = $clog2(NB);
    localparam int LANE_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH_WORDS * NB);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]        r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic              r_byte;
    logic [ADDR_W-1:0] r_adr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_ready;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    logic [IDX_W-1:0]  w_idx;
    logic [LANE_W-1:0] w_lane;
    logic              w_oob;
    logic              w_mmio_hit;
    logic              w_mmio;
    logic              w_err;
    logic              w_resp;
    logic [DATA_W-1:0] w_led;
    logic [DATA_W-1:0] w_word;
    logic [7:0]        w_byte;
    logic [DATA_W-1:0] w_load;
    logic [DATA_W-1:0] w_wr_data;
    logic [NB-1:0]     w_be;

`ifdef DMEM_MMIO_EN
    localparam logic MMIO_EN = 1'b1;
    logic [DATA_W-1:0] r_led;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_led <= '0;
        end else if (w_resp && r_we && w_mmio) begin
            for (int b = 0; b < NB; b++) begin
                if (w_be[b]) r_led[b*8 +: 8] <= w_wr_data[b*8 +: 8];
            end
        end
    end

    assign w_led = r_led;
`else
    localparam logic MMIO_EN = 1'b0;
    assign w_led = '0;
`endif

    // Decode works on the latched request only, so input changes during WAIT/RESP are invisible.
    assign w_idx      = IDX_W'(r_adr >> OFF);
    assign w_lane     = (NB > 1) ? LANE_W'(r_adr) : '0;
    assign w_oob      = ({1'b0, r_adr} >= LIMIT);
    assign w_mmio_hit = ((r_adr >> OFF) == (MMIO_ADDR >> OFF));
    assign w_mmio     = MMIO_EN && w_mmio_hit;
    assign w_err      = w_oob && !w_mmio;
    assign w_resp     = (r_state == S_RESP);

    assign w_word    = w_mmio ? w_led : r_mem[w_idx];
    assign w_byte    = w_word[{w_lane, 3'b000} +: 8];
    assign w_load    = r_byte ? DATA_W'(w_byte) : w_word;
    assign w_wr_data = r_byte ? {NB{r_wdata[7:0]}} : r_wdata;

    always_comb begin
        w_be = '0;
        for (int b = 0; b < NB; b++) begin
            w_be[b] = !r_byte || (w_lane == LANE_W'(b));
        end
    end

    // NOTE: state registers use non-blocking assignments so every register in this block samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            case (r_state)
                S_IDLE: begin
                    // The ready cycle itself is the mandatory idle gap; a still-high request is not re-accepted.
                    if (mem_req && !r_ready) begin
                        r_we    <= MemWrite;
                        r_byte  <= byte_op;
                        r_adr   <= DataAdr;
                        r_wdata <= WriteData;
                        r_cnt   <= 4'(WAIT_STATES);
                        r_state <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) r_state <= S_RESP;
                end
                S_RESP: begin
                    r_ready <= 1'b1;
                    r_err   <= w_err;
                    r_rdata <= (r_we || w_err) ? '0 : w_load;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the array has no reset; contents survive rst, only the commit is blocked while rst is high.
    always_ff @(posedge clk) begin
        if (w_resp && r_we && !w_oob && !w_mmio && !rst) begin
            for (int b = 0; b < NB; b++) begin
                if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wr_data[b*8 +: 8];
            end
        end
    end

    assign ReadData  = r_rdata;
    assign mem_ready = r_ready;
    assign err       = r_err;
    assign stall     = mem_req & ~r_ready;
    assign led_out   = w_led;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl: one instance with WAIT_STATES=1, one with WAIT_STATES=0.
module tb_dmem_ctrl;

`ifdef DMEM_MMIO_EN
    localparam bit MMIO = 1'b1;
`else
    localparam bit MMIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_req    [2];
    logic        mem_write  [2];
    logic        byte_op    [2];
    logic [31:0] data_adr   [2];
    logic [31:0] write_data [2];
    logic [31:0] read_data  [2];
    logic [31:0] led_out    [2];
    logic        mem_ready  [2];
    logic        stall      [2];
    logic        err        [2];

    int checks   = 0;
    int failures = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          stl;
    logic [31:0] led;

    always #5 clk = ~clk;

    dmem_ctrl u_dut_ws1 (
        .clk(clk), .rst(rst), .mem_req(mem_req[0]), .MemWrite(mem_write[0]), .byte_op(byte_op[0]),
        .DataAdr(data_adr[0]), .WriteData(write_data[0]), .ReadData(read_data[0]),
        .mem_ready(mem_ready[0]), .stall(stall[0]), .err(err[0]), .led_out(led_out[0])
    );

    dmem_ctrl #(.WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .rst(rst), .mem_req(mem_req[1]), .MemWrite(mem_write[1]), .byte_op(byte_op[1]),
        .DataAdr(data_adr[1]), .WriteData(write_data[1]), .ReadData(read_data[1]),
        .mem_ready(mem_ready[1]), .stall(stall[1]), .err(err[1]), .led_out(led_out[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic access(input int d, input logic we, input logic bop, input logic [31:0] adr,
                          input logic [31:0] wd, output logic [31:0] o_rd, output logic o_er,
                          output int o_lat, output int o_stl, output logic [31:0] o_led);
        bit done;
        done          = 1'b0;
        mem_req[d]    = 1'b1;
        mem_write[d]  = we;
        byte_op[d]    = bop;
        data_adr[d]   = adr;
        write_data[d] = wd;
        @(posedge clk);
        #1;
        mem_write[d]  = ~we;
        byte_op[d]    = ~bop;
        data_adr[d]   = adr ^ 32'h0000_0040;
        write_data[d] = ~wd;
        o_lat = 0;
        o_stl = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (mem_ready[d]) begin
                done = 1'b1;
            end else begin
                if (stall[d]) o_stl++;
                check("rdata_zero_before_ready", read_data[d], 32'h0);
                @(posedge clk);
                o_lat++;
            end
        end
        if (!done) o_lat = 99;
        o_rd  = read_data[d];
        o_er  = err[d];
        o_led = led_out[d];
        mem_req[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("ready_single_pulse", {31'b0, mem_ready[d]}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            mem_req[d] = 1'b0; mem_write[d] = 1'b0; byte_op[d] = 1'b0;
            data_adr[d] = 32'h0; write_data[d] = 32'h0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_ready", {31'b0, mem_ready[0]}, 32'h0);
            check("idle_err",   {31'b0, err[0]},       32'h0);
            check("idle_rdata", read_data[0],          32'h0);
            check("idle_stall", {31'b0, stall[0]},     32'h0);
        end
        check("idle_led0", led_out[0], 32'h0);
        check("idle_led1", led_out[1], 32'h0);

        // Word store/load, latency WAIT_STATES+1 = 2
        access(0, 1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, er, lat, stl, led);
        check("st10_latency", lat, 2);
        check("st10_stall",   stl, 2);
        check("st10_err",     {31'b0, er}, 32'h0);
        access(0, 1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat, stl, led);
        check("ld10_data",    rd, 32'hDEAD_BEEF);
        check("ld10_latency", lat, 2);
        check("ld10_stall",   stl, 2);
        check("ld10_err",     {31'b0, er}, 32'h0);

        // Byte lanes
        access(0, 1'b1, 1'b0, 32'h10, 32'h0000_0000, rd, er, lat, stl, led);
        access(0, 1'b1, 1'b1, 32'h11, 32'hFFFF_FFA5, rd, er, lat, stl, led);
        access(0, 1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat, stl, led);
        check("ld10_after_sb11", rd, 32'h0000_A500);
        access(0, 1'b0, 1'b1, 32'h11, 32'h0, rd, er, lat, stl, led);
        check("lb11", rd, 32'h0000_00A5);
        access(0, 1'b0, 1'b1, 32'h10, 32'h0, rd, er, lat, stl, led);
        check("lb10", rd, 32'h0000_0000);
        access(0, 1'b1, 1'b1, 32'h13, 32'h1234_567E, rd, er, lat, stl, led);
        access(0, 1'b0, 1'b0, 32'h12, 32'h0, rd, er, lat, stl, led);
        check("ld12_aligned", rd, 32'h7E00_A500);
        access(0, 1'b0, 1'b1, 32'h13, 32'h0, rd, er, lat, stl, led);
        check("lb13_lane3", rd, 32'h0000_007E);

        // Range boundary: 0xFC last valid word, 0x100 first invalid
        access(0, 1'b1, 1'b0, 32'h00, 32'h0BAD_F00D, rd, er, lat, stl, led);
        access(0, 1'b1, 1'b0, 32'hFC, 32'hCAFE_0001, rd, er, lat, stl, led);
        check("stFC_err", {31'b0, er}, 32'h0);
        access(0, 1'b1, 1'b0, 32'h100, 32'h1111_1111, rd, er, lat, stl, led);
        check("st100_err",     {31'b0, er}, 32'h1);
        check("st100_latency", lat, 2);
        access(0, 1'b0, 1'b0, 32'h100, 32'h0, rd, er, lat, stl, led);
        check("ld100_err",  {31'b0, er}, 32'h1);
        check("ld100_data", rd, 32'h0);
        access(0, 1'b0, 1'b0, 32'h00, 32'h0, rd, er, lat, stl, led);
        check("ld00_unchanged", rd, 32'h0BAD_F00D);
        check("ld00_err", {31'b0, er}, 32'h0);
        access(0, 1'b0, 1'b0, 32'hFC, 32'h0, rd, er, lat, stl, led);
        check("ldFC_data", rd, 32'hCAFE_0001);

        // Reset during WAIT and during RESP aborts the store
        access(0, 1'b1, 1'b0, 32'h20, 32'h55AA_55AA, rd, er, lat, stl, led);
        access(0, 1'b1, 1'b0, 32'h24, 32'h0F0F_0F0F, rd, er, lat, stl, led);

        mem_req[0] = 1'b1; mem_write[0] = 1'b1; byte_op[0] = 1'b0;
        data_adr[0] = 32'h20; write_data[0] = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        mem_req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("rst_wait_no_ready", {31'b0, mem_ready[0]}, 32'h0);
            @(negedge clk);
        end

        mem_req[0] = 1'b1; mem_write[0] = 1'b1; byte_op[0] = 1'b0;
        data_adr[0] = 32'h24; write_data[0] = 32'h8765_4321;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mem_req[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check("rst_resp_no_ready", {31'b0, mem_ready[0]}, 32'h0);
            @(negedge clk);
        end

        access(0, 1'b0, 1'b0, 32'h20, 32'h0, rd, er, lat, stl, led);
        check("ld20_prior", rd, 32'h55AA_55AA);
        check("ld20_latency", lat, 2);
        access(0, 1'b0, 1'b0, 32'h24, 32'h0, rd, er, lat, stl, led);
        check("ld24_prior", rd, 32'h0F0F_0F0F);
        access(0, 1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat, stl, led);
        check("ld10_survives_rst", rd, 32'h7E00_A500);

        // Zero wait states
        access(1, 1'b1, 1'b0, 32'h08, 32'h1357_9BDF, rd, er, lat, stl, led);
        check("ws0_st_latency", lat, 1);
        check("ws0_st_stall",   stl, 1);
        access(1, 1'b0, 1'b0, 32'h08, 32'h0, rd, er, lat, stl, led);
        check("ws0_ld_data",    rd, 32'h1357_9BDF);
        check("ws0_ld_latency", lat, 1);

        // Output register address
        access(1, 1'b1, 1'b0, 32'h400, 32'h0000_00FF, rd, er, lat, stl, led);
        check("mmio_st_latency", lat, 1);
        check("mmio_st_err", {31'b0, er}, MMIO ? 32'h0 : 32'h1);
        check("mmio_st_led", led, MMIO ? 32'h0000_00FF : 32'h0);
        access(1, 1'b0, 1'b0, 32'h400, 32'h0, rd, er, lat, stl, led);
        check("mmio_ld_data", rd, MMIO ? 32'h0000_00FF : 32'h0);
        check("mmio_ld_err", {31'b0, er}, MMIO ? 32'h0 : 32'h1);
        access(1, 1'b1, 1'b1, 32'h401, 32'h0000_AB3C, rd, er, lat, stl, led);
        check("mmio_sb_led", led, MMIO ? 32'h0000_3CFF : 32'h0);
        access(1, 1'b0, 1'b1, 32'h401, 32'h0, rd, er, lat, stl, led);
        check("mmio_lb_data", rd, MMIO ? 32'h0000_003C : 32'h0);
        check("led0_untouched", led_out[0], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
